// File: rtl/pipe_scoreboard_rf_if.sv
// ---------------------------------------------------------------------------
// pipe_scoreboard_rf_if
//   Bundles the ID-stage issue signals, the WB-stage write-back signals and
//   the scoreboard status outputs of pipe_scoreboard_rf.
//
//   master : pipeline side (drives issue_* / wb_*, observes status)
//   slave  : register file / scoreboard side
//
//   issue_valid, issue_rs, issue_rt, issue_rd,
//   issue_rs_used, issue_rt_used, issue_wr      -> instruction presented by ID
//   stall, rs_data, rt_data                     <- issue response / operands
//   wb_valid, wb_rd, wb_data                    -> write-back from WB
//   pending_mask, stall_count, deadlock         <- scoreboard status
// ---------------------------------------------------------------------------
interface pipe_scoreboard_rf_if #(
    parameter int REG_AW      = 3,
    parameter int DATA_W      = 16,
    parameter int STALL_CNT_W = 16
);
    localparam int NREGS = 1 << REG_AW;

    logic                   issue_valid;
    logic [REG_AW-1:0]      issue_rs;
    logic [REG_AW-1:0]      issue_rt;
    logic [REG_AW-1:0]      issue_rd;
    logic                   issue_rs_used;
    logic                   issue_rt_used;
    logic                   issue_wr;
    logic                   stall;
    logic [DATA_W-1:0]      rs_data;
    logic [DATA_W-1:0]      rt_data;
    logic                   wb_valid;
    logic [REG_AW-1:0]      wb_rd;
    logic [DATA_W-1:0]      wb_data;
    logic [NREGS-1:0]       pending_mask;
    logic [STALL_CNT_W-1:0] stall_count;
    logic                   deadlock;

    modport master (
        output issue_valid, issue_rs, issue_rt, issue_rd,
               issue_rs_used, issue_rt_used, issue_wr,
               wb_valid, wb_rd, wb_data,
        input  stall, rs_data, rt_data, pending_mask, stall_count, deadlock
    );

    modport slave (
        input  issue_valid, issue_rs, issue_rt, issue_rd,
               issue_rs_used, issue_rt_used, issue_wr,
               wb_valid, wb_rd, wb_data,
        output stall, rs_data, rt_data, pending_mask, stall_count, deadlock
    );
endinterface

// File: rtl/pipe_scoreboard_rf.sv
// ---------------------------------------------------------------------------
// pipe_scoreboard_rf
//   Register file with an in-flight destination scoreboard for an in-order,
//   single-issue pipeline. Stalls issue on RAW/WAW hazards, forwards the
//   same-cycle write-back value to the read ports, keeps a saturating count
//   of stall cycles and raises a sticky deadlock flag when a stall persists
//   for TIMEOUT consecutive cycles.
//
//   clk1  : clock, all state changes on the rising edge
//   reset : synchronous, active-high; clears registers, scoreboard, counters
//   bus   : pipe_scoreboard_rf_if.slave (issue, write-back and status)
// ---------------------------------------------------------------------------
module pipe_scoreboard_rf #(
    parameter int REG_AW      = 3,
    parameter int DATA_W      = 16,
    parameter int STALL_CNT_W = 16,
    parameter int TIMEOUT     = 64
) (
    input  logic                 clk1,
    input  logic                 reset,
    pipe_scoreboard_rf_if.slave  bus
);
    localparam int NREGS = 1 << REG_AW;
    localparam int RUN_W = $clog2(TIMEOUT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX    = RUN_W'(TIMEOUT);
    localparam logic [RUN_W-1:0] RUN_MAX_M1 = RUN_W'(TIMEOUT - 1);

    logic [DATA_W-1:0]      r_rf [NREGS];
    logic [NREGS-1:0]       r_pending;
    logic [STALL_CNT_W-1:0] r_stallCount;
    logic [RUN_W-1:0]       r_run;
    logic                   r_deadlock;

    logic                   w_wbHitRs;
    logic                   w_wbHitRt;
    logic                   w_rawRs;
    logic                   w_rawRt;
    logic                   w_waw;
    logic                   w_stall;
    logic                   w_accept;
    logic [DATA_W-1:0]      w_rsData;
    logic [DATA_W-1:0]      w_rtData;
    logic [NREGS-1:0]       w_pendingNext;

    // Hazard detection. A source whose producer is writing back this very
    // cycle is satisfied by the bypass, so it does not stall. WAW gets no
    // such exemption: the new pending bit must not collide with the clear.
    always_comb begin
        w_wbHitRs = bus.wb_valid && (bus.wb_rd == bus.issue_rs) && (bus.issue_rs != '0);
        w_wbHitRt = bus.wb_valid && (bus.wb_rd == bus.issue_rt) && (bus.issue_rt != '0);
        w_rawRs   = bus.issue_rs_used && r_pending[bus.issue_rs] && !w_wbHitRs;
        w_rawRt   = bus.issue_rt_used && r_pending[bus.issue_rt] && !w_wbHitRt;
        w_waw     = bus.issue_wr && (bus.issue_rd != '0) && r_pending[bus.issue_rd];
        w_stall   = bus.issue_valid && (w_rawRs || w_rawRt || w_waw);
        w_accept  = bus.issue_valid && !w_stall;
    end

    // Operand read: R0 reads zero, then write-back bypass, then stored value.
    always_comb begin
        w_rsData = r_rf[bus.issue_rs];
        if (bus.issue_rs == '0) begin
            w_rsData = '0;
        end else if (bus.wb_valid && (bus.wb_rd == bus.issue_rs)) begin
            w_rsData = bus.wb_data;
        end

        w_rtData = r_rf[bus.issue_rt];
        if (bus.issue_rt == '0) begin
            w_rtData = '0;
        end else if (bus.wb_valid && (bus.wb_rd == bus.issue_rt)) begin
            w_rtData = bus.wb_data;
        end
    end

    // Next scoreboard state: write-back clears, accepted writer sets.
    // R0 is forced clear so it can never become pending.
    always_comb begin
        w_pendingNext = r_pending;
        if (bus.wb_valid) begin
            w_pendingNext[bus.wb_rd] = 1'b0;
        end
        if (w_accept && bus.issue_wr && (bus.issue_rd != '0)) begin
            w_pendingNext[bus.issue_rd] = 1'b1;
        end
        w_pendingNext[0] = 1'b0;
    end

    // Register file storage, scoreboard and stall statistics. The deadlock
    // flag is set on the same edge at which the run counter reaches TIMEOUT.
    always_ff @(posedge clk1) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_rf[i] <= '0;
            end
            r_pending    <= '0;
            r_stallCount <= '0;
            r_run        <= '0;
            r_deadlock   <= 1'b0;
        end else begin
            if (bus.wb_valid && (bus.wb_rd != '0)) begin
                r_rf[bus.wb_rd] <= bus.wb_data;
            end
            r_pending <= w_pendingNext;

            if (w_stall && (r_stallCount != '1)) begin
                r_stallCount <= r_stallCount + STALL_CNT_W'(1);
            end

            if (!w_stall) begin
                r_run <= '0;
            end else if (r_run != RUN_MAX) begin
                r_run <= r_run + RUN_W'(1);
            end

            if (w_stall && (r_run >= RUN_MAX_M1)) begin
                r_deadlock <= 1'b1;
            end
        end
    end

    assign bus.stall        = w_stall;
    assign bus.rs_data      = w_rsData;
    assign bus.rt_data      = w_rtData;
    assign bus.pending_mask = r_pending;
    assign bus.stall_count  = r_stallCount;
    assign bus.deadlock     = r_deadlock;

endmodule

// File: doc/pipe_scoreboard_rf.md
Name: pipe_scoreboard_rf

Overview:
- Parametrised register file with hazard scoreboard for the pipelined MIPS16 core family.
- Tracks in-flight destination registers. Stalls the decode/issue stage on RAW and WAW hazards. Bypasses same-cycle write-back data to the read ports.
- Removes the need for software NOP padding (dummy OR R7,R7,R7) between dependent instructions.
- Sits between ID (read/issue) and WB (write-back); widths generalised so the same block serves 16- and 32-bit cores.

Parameters:
REG_AW, 3, register address width; NREGS = 2**REG_AW registers
DATA_W, 16, register data width
STALL_CNT_W, 16, width of stall statistics counter
TIMEOUT, 64, consecutive stall cycles before deadlock flag asserts (must be >=2)

Ports:
clk1  in  1  single system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
issue_valid  in  1  ID stage presents an instruction
issue_rs  in  REG_AW  source register 1
issue_rt  in  REG_AW  source register 2
issue_rd  in  REG_AW  destination register
issue_rs_used  in  1  instruction reads rs
issue_rt_used  in  1  instruction reads rt
issue_wr  in  1  instruction will write rd
stall  out  1  hold ID/IF this cycle; instruction not accepted
rs_data  out  DATA_W  operand for rs (bypassed)
rt_data  out  DATA_W  operand for rt (bypassed)
wb_valid  in  1  write-back this cycle
wb_rd  in  REG_AW  write-back destination
wb_data  in  DATA_W  write-back value
pending_mask  out  NREGS  bit i set = write to Ri in flight
stall_count  out  STALL_CNT_W  total stall cycles since reset, saturating
deadlock  out  1  sticky: stall held TIMEOUT consecutive cycles

Behaviour:
- Reset (sync, high): all registers clear to 0, pending_mask=0, stall_count=0, deadlock=0, internal stall-run counter=0. A wb_valid in the reset cycle is ignored. Reset mid-operation discards all in-flight tracking.
- R0 is hardwired 0. Writes to R0 are dropped. R0 is never pending. Reads of R0 return 0 even under bypass.
- Reads are combinational, with rs_data evaluated in priority order:
  - rs==0 gives 0.
  - Otherwise wb_valid && wb_rd==rs gives wb_data (bypass).
  - Otherwise rf[rs].
  - rt_data follows the same rules.
- Hazard terms:
  - wbhit(x) = wb_valid && wb_rd==x && x!=0.
  - RAW_rs = issue_rs_used && pending[rs] && !wbhit(rs). RAW_rt is analogous.
  - WAW = issue_wr && rd!=0 && pending[rd]. No bypass exemption applies to WAW.
  - stall = issue_valid && (RAW_rs || RAW_rt || WAW). This is purely combinational.
- Accept: issue_valid && !stall. On accept with issue_wr && rd!=0, pending[rd] sets at the next edge.
- Write-back: on wb_valid, rf[wb_rd] <= wb_data and pending[wb_rd] clears at the edge.
  - A set and a clear of the same bit in one cycle cannot occur, because WAW stalls.
  - wb_valid to a non-pending register still writes (external/debug writes allowed).
- stall_count increments by 1 on every cycle stall=1 and saturates at all-ones.
- Stall-run counter:
  - Increments while stall=1 and resets to 0 when stall=0.
  - When it reaches TIMEOUT, deadlock sets and remains set until reset.
  - The counter itself saturates at TIMEOUT.
- Single issue, in order. Latency from WB edge to visible rf read is 0 cycles via bypass and 1 edge for stored value.

Test Plan:
- Reset then issue ADDI R1 (rd=1, wr, rs=0 used) -> stall=0; next cycle pending_mask=8'b0000_0010. Then wb R1=10 -> pending_mask=0 and rs_data for rs=1 reads 10.
- RAW: pending R1 and R2, issue ADD R4,R1,R2 with no wb -> stall=1 for 3 cycles and stall_count=3. Then wb R1=10 the same cycle as wb R2=20 is not possible, so:
  - wb R1, then wb R2=20 with the issue held -> stall drops in the wb R2 cycle.
  - rs_data=10 and rt_data=20 (bypass).
- WAW: R5 pending, issue wr rd=5 -> stall=1. When wb_rd=5 arrives, stall stays 1 that cycle and drops the next cycle.
- R0: issue wr rd=0 -> no pending bit. Then wb_rd=0 with data 16'hFFFF -> rs_data for rs=0 reads 0.
- Deadlock: TIMEOUT=64, R3 pending, RAW issue held without wb -> deadlock=0 at cycle 63, deadlock=1 at cycle 64. It stays 1 after the stall clears and drops only on reset.
- Reset mid-flight: pending_mask=8'b0011_0110, assert reset with wb_valid=1 -> pending_mask=0, all reads 0, stall_count=0.
